// File: rtl/enemy_spawner_if.sv
// Enemy spawner game bus: control pulses in, display/score state out.
interface enemy_spawner_if;
    logic       start;
    logic       tick;
    logic       key_valid;
    logic [3:0] key_code;
    logic [4:0] pos_0;
    logic [4:0] pos_1;
    logic [4:0] pos_2;
    logic       hit;
    logic [7:0] score;
    logic [3:0] escapes;
    logic       game_over;

    // Game controller / stimulus side
    modport master (
        output start, tick, key_valid, key_code,
        input  pos_0, pos_1, pos_2, hit, score, escapes, game_over
    );

    // Spawner side
    modport slave (
        input  start, tick, key_valid, key_code,
        output pos_0, pos_1, pos_2, hit, score, escapes, game_over
    );
endinterface

// File: rtl/enemy_spawner.sv
// Whack-a-mole style enemy spawner: three enemy slots over a 3x3 hole grid,
// LFSR-driven spawning, key whacks, lifetime expiry, score and escape counts.
// Timing notes:
//  - the gap counter counts ticks since the last successful spawn; a spawn is
//    attempted on the SPAWN_GAP-th tick and on every tick after that until one
//    succeeds.
//  - all decisions in a cycle use the slot contents as they were at the start
//    of that cycle, so a slot emptied this cycle is not refilled this cycle.
module enemy_spawner #(
    parameter int          LIFETIME   = 60,
    parameter int          SPAWN_GAP  = 20,
    parameter int          HIT_FLASH  = 8,
    parameter int          MAX_ESCAPE = 10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic            clk,
    input logic            rst,
    enemy_spawner_if.slave bus
);

    localparam int NSLOT = 3;
    localparam int LW    = $clog2(LIFETIME + 1);
    localparam int GW    = $clog2(SPAWN_GAP + 1);
    localparam int FW    = $clog2(HIT_FLASH + 1);
    localparam logic [3:0] MAX_E = 4'(MAX_ESCAPE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_e;

    state_e                     state_q, state_d;
    logic [15:0]                lfsr_q, lfsr_d;
    logic [NSLOT-1:0][3:0]      hole_q, hole_d;   // 0 = EMPTY, else hole 1..9
    logic [NSLOT-1:0][LW-1:0]   life_q, life_d;
    logic [GW-1:0]              gap_q, gap_d;
    logic [FW-1:0]              flash_q, flash_d;
    logic [7:0]                 score_q, score_d;
    logic [3:0]                 esc_q, esc_d;
    logic [NSLOT-1:0][4:0]      pos_q, pos_d;
    logic                       hit_q, hit_d;
    logic                       over_q, over_d;

    logic [NSLOT-1:0]           whack;
    logic [3:0]                 cand;
    logic                       held;
    logic                       free_any;
    logic [1:0]                 free_slot;
    logic [1:0]                 n_esc;
    logic [4:0]                 esc_sum;
    logic [GW-1:0]              gap_inc;

    // Slot, spawn, whack, expiry, score and LFSR next-state
    always_comb begin
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        hole_d    = hole_q;
        life_d    = life_q;
        gap_d     = gap_q;
        flash_d   = flash_q;
        score_d   = score_q;
        esc_d     = esc_q;
        whack     = '0;
        held      = 1'b0;
        free_any  = 1'b0;
        free_slot = 2'd0;
        n_esc     = 2'd0;
        esc_sum   = 5'd0;
        gap_inc   = gap_q;
        cand      = lfsr_q[3:0] + 4'd1;

        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (hole_q[i] == 4'd0) begin
                free_any  = 1'b1;
                free_slot = 2'(i);
            end else begin
                held     = held | (hole_q[i] == cand);
                whack[i] = (state_q == S_RUN) && bus.key_valid && (bus.key_code == hole_q[i]);
            end
        end

        if (state_q != S_RUN) begin
            if (bus.start) begin
                hole_d  = '0;
                life_d  = '0;
                gap_d   = '0;
                flash_d = '0;
                score_d = '0;
                esc_d   = '0;
            end else if (bus.tick && flash_q != '0) begin
                flash_d = flash_q - FW'(1);
            end
        end else begin
            // A whack reloads the flash even when a tick arrives in the same cycle
            if (|whack) begin
                score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                flash_d = FW'(HIT_FLASH);
            end else if (bus.tick && flash_q != '0) begin
                flash_d = flash_q - FW'(1);
            end

            for (int i = 0; i < NSLOT; i++) begin
                if (whack[i]) begin
                    hole_d[i] = 4'd0;
                end else if (bus.tick && hole_q[i] != 4'd0) begin
                    if (life_q[i] == LW'(LIFETIME - 1)) begin
                        hole_d[i] = 4'd0;
                        n_esc     = n_esc + 2'd1;
                    end else begin
                        life_d[i] = life_q[i] + LW'(1);
                    end
                end
            end

            if (bus.tick) begin
                gap_inc = (gap_q == GW'(SPAWN_GAP)) ? gap_q : gap_q + GW'(1);
                gap_d   = gap_inc;
                if (gap_inc == GW'(SPAWN_GAP) && lfsr_q[3:0] < 4'd9 && !held && free_any) begin
                    hole_d[free_slot] = cand;
                    life_d[free_slot] = '0;
                    gap_d             = '0;
                end
            end

            esc_sum = {1'b0, esc_q} + {3'b000, n_esc};
            esc_d   = (esc_sum >= {1'b0, MAX_E}) ? MAX_E : esc_sum[3:0];
        end
    end

    // Game FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_OVER: if (bus.start) state_d = S_RUN;
            S_RUN:          if (esc_d == MAX_E) state_d = S_OVER;
            default:        state_d = S_IDLE;
        endcase
    end

    // Output register images, computed from next-state values
    always_comb begin
        pos_d[0] = {1'b0, hole_d[0]};
        pos_d[1] = {1'b0, hole_d[1]};
        pos_d[2] = (hole_d[2] == 4'd0) ? 5'd0 : {1'b0, hole_d[2]} + 5'd11;
        hit_d    = (flash_d != '0);
        over_d   = (state_d == S_OVER);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q  <= LFSR_SEED;
            hole_q  <= '0;
            life_q  <= '0;
            gap_q   <= '0;
            flash_q <= '0;
            score_q <= '0;
            esc_q   <= '0;
            pos_q   <= '0;
            hit_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            hole_q  <= hole_d;
            life_q  <= life_d;
            gap_q   <= gap_d;
            flash_q <= flash_d;
            score_q <= score_d;
            esc_q   <= esc_d;
            pos_q   <= pos_d;
            hit_q   <= hit_d;
            over_q  <= over_d;
        end
    end

    assign bus.pos_0     = pos_q[0];
    assign bus.pos_1     = pos_q[1];
    assign bus.pos_2     = pos_q[2];
    assign bus.hit       = hit_q;
    assign bus.score     = score_q;
    assign bus.escapes   = esc_q;
    assign bus.game_over = over_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// Bench for enemy_spawner: constant vector table, directed game scenarios and
// a randomized run, all against a game-rules model kept here.
module tb_enemy_spawner;

    localparam int          LIFETIME   = 60;
    localparam int          SPAWN_GAP  = 20;
    localparam int          HIT_FLASH  = 8;
    localparam int          MAX_ESCAPE = 10;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    enemy_spawner_if bus();

    enemy_spawner #(
        .LIFETIME(LIFETIME), .SPAWN_GAP(SPAWN_GAP), .HIT_FLASH(HIT_FLASH),
        .MAX_ESCAPE(MAX_ESCAPE), .LFSR_SEED(LFSR_SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Game model: holes per slot (0 = empty), ticks alive, ticks since spawn
    int          m_hole[3];
    int          m_age[3];
    int          m_score, m_esc, m_flash, m_since;
    int          m_mode;       // 0 idle, 1 running, 2 over
    bit [15:0]   m_lfsr;

    function automatic bit [15:0] lfsr_next(input bit [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic clear_game();
        for (int i = 0; i < 3; i++) begin m_hole[i] = 0; m_age[i] = 0; end
        m_score = 0; m_esc = 0; m_flash = 0; m_since = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit t, input bit kv, input bit [3:0] kc);
        int w, nib, slot;
        int old[3];
        bit taken;
        if (r) begin
            clear_game();
            m_mode = 0;
            m_lfsr = LFSR_SEED;
        end else begin
            nib    = int'(m_lfsr[3:0]);
            m_lfsr = lfsr_next(m_lfsr);
            if (m_mode != 1) begin
                if (s) begin
                    m_mode = 1;
                    clear_game();
                end else if (t && m_flash > 0) m_flash--;
            end else begin
                old = m_hole;
                w   = -1;
                if (kv) for (int i = 0; i < 3; i++) if (old[i] != 0 && old[i] == int'(kc)) w = i;
                if (w >= 0) begin
                    m_hole[w] = 0;
                    if (m_score < 255) m_score++;
                    m_flash = HIT_FLASH;
                end else if (t && m_flash > 0) m_flash--;
                if (t) begin
                    for (int i = 0; i < 3; i++) begin
                        if (old[i] != 0 && i != w) begin
                            if (m_age[i] == LIFETIME - 1) begin
                                m_hole[i] = 0;
                                if (m_esc < MAX_ESCAPE) m_esc++;
                            end else m_age[i]++;
                        end
                    end
                    if (m_since < SPAWN_GAP) m_since++;
                    taken = 1'b0;
                    for (int i = 0; i < 3; i++) if (old[i] == nib + 1) taken = 1'b1;
                    if (m_since == SPAWN_GAP && nib < 9 && !taken) begin
                        slot = -1;
                        for (int i = 2; i >= 0; i--) if (old[i] == 0) slot = i;
                        if (slot >= 0) begin
                            m_hole[slot] = nib + 1;
                            m_age[slot]  = 0;
                            m_since      = 0;
                        end
                    end
                end
                if (m_esc == MAX_ESCAPE) m_mode = 2;
            end
        end
    endtask

    function automatic logic [28:0] exp_vec();
        logic [4:0] p2;
        p2 = (m_hole[2] != 0) ? 5'(m_hole[2] + 11) : 5'd0;
        return {5'(m_hole[0]), 5'(m_hole[1]), p2, (m_flash > 0), 8'(m_score), 4'(m_esc), (m_mode == 2)};
    endfunction

    function automatic logic [28:0] dut_vec();
        return {bus.pos_0, bus.pos_1, bus.pos_2, bus.hit, bus.score, bus.escapes, bus.game_over};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, step the model at the edge, compare after it
    task automatic cyc(input bit r, input bit s, input bit t, input bit kv, input bit [3:0] kc);
        rst = r; bus.start = s; bus.tick = t; bus.key_valid = kv; bus.key_code = kc;
        @(posedge clk);
        model_step(r, s, t, kv, kc);
        #1;
        check("model", 32'(dut_vec()), 32'(exp_vec()));
        rst = 1'b0; bus.start = 1'b0; bus.tick = 1'b0; bus.key_valid = 1'b0; bus.key_code = 4'd0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    endtask

    task automatic new_game();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    // Tick until a spawn attempt is due, then tick exactly when lfsr[3:0]==nib
    task automatic tick_at(input int nib);
        int guard;
        guard = 0;
        while (m_since + 1 < SPAWN_GAP && guard < 200) begin ticks(1); guard++; end
        guard = 0;
        while (int'(m_lfsr[3:0]) != nib && guard < 2000) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            guard++;
        end
        check("lfsr_wait_bound", 32'(guard < 2000), 32'd1);
        ticks(1);
    endtask

    typedef struct {
        bit r, s, t, kv;
        bit [3:0] kc;
        bit [4:0] p0;
        bit       hit;
        bit [7:0] score;
        bit [3:0] esc;
        bit       go;
    } vec_t;

    vec_t vt[10];

    initial begin
        int guard;
        bit r, s, t, kv;
        bit [3:0] kc;

        bus.start = 1'b0; bus.tick = 1'b0; bus.key_valid = 1'b0; bus.key_code = 4'd0;
        clear_game(); m_mode = 0; m_lfsr = LFSR_SEED;

        // Control basics: reset state, IDLE ignores keys, start ignored in RUN
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  5'd0, 1'b0, 8'd0, 4'd0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  5'd0, 1'b0, 8'd0, 4'd0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  5'd0, 1'b0, 8'd0, 4'd0, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  5'd0, 1'b0, 8'd0, 4'd0, 1'b0};
        vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  5'd0, 1'b0, 8'd0, 4'd0, 1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 5'd0, 1'b0, 8'd0, 4'd0, 1'b0};
        vt[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  5'd0, 1'b0, 8'd0, 4'd0, 1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  5'd0, 1'b0, 8'd0, 4'd0, 1'b0};
        vt[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  5'd0, 1'b0, 8'd0, 4'd0, 1'b0};
        vt[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  5'd0, 1'b0, 8'd0, 4'd0, 1'b0};
        for (int k = 0; k < 10; k++) begin
            cyc(vt[k].r, vt[k].s, vt[k].t, vt[k].kv, vt[k].kc);
            check($sformatf("vec%0d", k),
                  32'({bus.pos_0, bus.pos_1, bus.pos_2, bus.hit, bus.score, bus.escapes, bus.game_over}),
                  32'({vt[k].p0, 10'd0, vt[k].hit, vt[k].score, vt[k].esc, vt[k].go}));
        end

        // First spawn on the SPAWN_GAP-th tick with lfsr[3:0]==4 lands hole 5 in slot 0
        new_game();
        tick_at(4);
        check("spawn_pos_0", 32'(bus.pos_0), 32'd5);
        check("spawn_pos_1", 32'(bus.pos_1), 32'd0);
        check("spawn_pos_2", 32'(bus.pos_2), 32'd0);

        // Whack hole 5, then flash lasts exactly HIT_FLASH ticks
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        check("whack_pos_0", 32'(bus.pos_0), 32'd0);
        check("whack_score", 32'(bus.score), 32'd1);
        check("whack_hit", 32'(bus.hit), 32'd1);
        for (int k = 1; k <= HIT_FLASH; k++) begin
            ticks(1);
            check($sformatf("flash_tick%0d", k), 32'(bus.hit), 32'(k < HIT_FLASH));
        end

        // Slot 2 at hole 3 escapes after LIFETIME ticks
        new_game();
        tick_at(4); tick_at(6); tick_at(2);
        check("slot2_pos", 32'(bus.pos_2), 32'd14);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        ticks(LIFETIME - 1);
        check("slot2_alive_pos", 32'(bus.pos_2), 32'd14);
        check("slot2_alive_esc", 32'(bus.escapes), 32'd0);
        ticks(1);
        check("slot2_expired_pos", 32'(bus.pos_2), 32'd0);
        check("slot2_expired_esc", 32'(bus.escapes), 32'd1);
        check("slot2_expired_score", 32'(bus.score), 32'd2);

        // Whack on the expiry tick: whack wins
        new_game();
        tick_at(4);
        ticks(LIFETIME - 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
        check("race_score", 32'(bus.score), 32'd1);
        check("race_esc", 32'(bus.escapes), 32'd0);
        check("race_pos_0", 32'(bus.pos_0), 32'd0);

        // Blocked candidates keep the spawn pending until a valid tick
        new_game();
        tick_at(4);
        tick_at(4);
        check("dup_hole_pos_1", 32'(bus.pos_1), 32'd0);
        tick_at(12);
        check("bad_nib_pos_1", 32'(bus.pos_1), 32'd0);
        tick_at(5);
        check("retry_pos_1", 32'(bus.pos_1), 32'd6);

        // Escapes end the game; OVER is frozen; start restarts cleanly
        new_game();
        guard = 0;
        while (!bus.game_over && guard < 5000) begin ticks(1); guard++; end
        check("over_bound", 32'(guard < 5000), 32'd1);
        check("over_flag", 32'(bus.game_over), 32'd1);
        check("over_esc", 32'(bus.escapes), 32'(MAX_ESCAPE));
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'(m_hole[0] != 0 ? m_hole[0] : m_hole[1]));
        ticks(SPAWN_GAP + 5);
        check("over_frozen_score", 32'(bus.score), 32'd0);
        check("over_frozen_esc", 32'(bus.escapes), 32'(MAX_ESCAPE));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("restart_over", 32'(bus.game_over), 32'd0);
        check("restart_pos", 32'({bus.pos_0, bus.pos_1, bus.pos_2}), 32'd0);
        check("restart_score", 32'(bus.score), 32'd0);

        // Randomized play against the model
        new_game();
        for (int k = 0; k < 6000; k++) begin
            r  = ($urandom_range(0, 799) == 0);
            s  = ($urandom_range(0, 149) == 0);
            t  = ($urandom_range(0, 2) == 0);
            kv = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) kc = 4'(m_hole[$urandom_range(0, 2)]);
            else                           kc = 4'($urandom_range(0, 15));
            cyc(r, s, t, kv, kc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
